// File: rtl/output_arbiter_pkg.sv
// Shared definitions for the output byte arbiter:
// FSM encoding, header tag and port count.
package output_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/output_arbiter_rr_select4.sv
// Round-robin selector: first set request bit searching
// upward (mod 4) from the pointer.
module rr_select4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // Walk from the farthest offset down so the nearest one wins.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Four-port record arbiter feeding one byte sink; each record
// is a tag header followed by REC_LEN payload bytes.
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int REC_LEN0 = 6,
  parameter int REC_LEN1 = 6,
  parameter int REC_LEN2 = 6,
  parameter int REC_LEN3 = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   port_en,
  input  logic [8*NUM_PORTS-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_rdy,
  output logic [NUM_PORTS-1:0]   req_ack,
  output logic [7:0]             out_data,
  output logic                   out_rdy,
  input  logic                   out_ack
);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] grant;
  logic [7:0] byte_cnt;

  logic [3:0] cand;
  logic [1:0] winner;
  logic       win_valid;
  logic [7:0] rec_len;
  logic [7:0] grant_byte;
  logic       grant_rdy;
  logic       last_byte;

  assign cand = req_rdy & port_en;

  rr_select4 u_sel (
    .req    (cand),
    .ptr    (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    rec_len = 8'(REC_LEN0);
    case (grant)
      2'd1:    rec_len = 8'(REC_LEN1);
      2'd2:    rec_len = 8'(REC_LEN2);
      2'd3:    rec_len = 8'(REC_LEN3);
      default: rec_len = 8'(REC_LEN0);
    endcase
  end

  assign grant_byte = req_data[{grant, 3'b000} +: 8];
  assign grant_rdy  = req_rdy[grant];
  assign last_byte  = (byte_cnt == rec_len - 8'd1);

  always_comb begin
    out_rdy  = 1'b0;
    out_data = 8'h00;
    req_ack  = '0;
    case (state)
      HEADER: begin
        out_rdy  = 1'b1;
        out_data = {HDR_TAG, 2'b00, grant};
      end
      PAYLOAD: begin
        out_rdy        = grant_rdy;
        out_data       = grant_byte;
        req_ack[grant] = out_ack & grant_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      grant    <= 2'd0;
      byte_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant <= winner;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (out_ack) begin
            state    <= PAYLOAD;
            byte_cnt <= 8'd0;
          end
        end
        PAYLOAD: begin
          // A stalled source leaves the count and state untouched.
          if (out_ack && grant_rdy) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (last_byte) begin
              state  <= IDLE;
              rr_ptr <= grant + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Scoreboard bench for output_arbiter: expected bytes are queued
// as records are requested and popped on each sink transfer.
module tb_output_arbiter;

  localparam int LEN [4] = '{6, 6, 6, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  port_en;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic [3:0]  req_ack;
  logic [7:0]  out_data;
  logic        out_rdy;
  logic        out_ack;

  logic [7:0]  cnt [4];
  int          exp_cnt [4];
  int          ack_count [4];
  logic [7:0]  q [$];
  int          checks = 0;
  int          errors = 0;

  output_arbiter #(
    .REC_LEN0(LEN[0]),
    .REC_LEN1(LEN[1]),
    .REC_LEN2(LEN[2]),
    .REC_LEN3(LEN[3])
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .port_en  (port_en),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .req_ack  (req_ack),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  // Source model: port n presents (n*16 + bytes_consumed + 1).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) cnt[n] <= 8'd0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (req_ack[n]) cnt[n] <= cnt[n] + 8'd1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int n = 0; n < 4; n++)
      req_data[8*n +: 8] = 8'(n * 16) + cnt[n] + 8'd1;
  end

  // Sink monitor
  always @(negedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++)
        if (req_ack[n]) ack_count[n]++;
      if (out_rdy && out_ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: got %h, expected none",
                   out_data);
        end else begin
          automatic logic [7:0] e = q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL stream_byte: got %h, expected %h",
                     out_data, e);
          end
        end
      end
    end
  end

  task automatic push_record(input int n);
    q.push_back(8'hA0 | 8'(n));
    for (int k = 0; k < LEN[n]; k++) begin
      q.push_back(8'(n * 16 + exp_cnt[n] + 1));
      exp_cnt[n]++;
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int n = 0; n < 4; n++) begin
      exp_cnt[n]   = 0;
      ack_count[n] = 0;
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    req_rdy = 4'b0000;
    out_ack = 1'b0;
    port_en = 4'b1111;
    @(posedge clk);
    #1;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int bound, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < bound) begin
      @(posedge clk);
      cycles++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left, expected 0",
               q.size());
    end
  endtask

  task automatic wait_left(input int left, input string nm);
    int c;
    c = 0;
    while (q.size() > left && c < 40) begin
      @(posedge clk);
      c++;
    end
    #1;
    checks++;
    if (q.size() > left) begin
      errors++;
      $display("FAIL %s_wait: got %0d left, expected %0d",
               nm, q.size(), left);
    end
  endtask

  task automatic check_acks(input int n, input int exp, input string nm);
    checks++;
    if (ack_count[n] !== exp) begin
      errors++;
      $display("FAIL %s_acks: got %0d, expected %0d",
               nm, ack_count[n], exp);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    port_en = 4'b0000;
    req_rdy = 4'b0000;
    out_ack = 1'b0;
    #1;
    checks += 3;
    if (out_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_rdy: got %b, expected 0", out_rdy);
    end
    if (req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ack: got %b, expected 0000", req_ack);
    end
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_data: got %h, expected 00", out_data);
    end
  endtask

  task automatic test_single_port();
    int cyc;
    apply_reset();
    req_rdy = 4'b0001;
    out_ack = 1'b1;
    push_record(0);
    drain(40, cyc);
    req_rdy = 4'b0000;
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL record_cost: got %0d cycles, expected 8", cyc);
    end
    check_acks(0, 6, "single");
    @(negedge clk);
    checks++;
    if (out_rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_rdy: got %b, expected 0", out_rdy);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    apply_reset();
    req_rdy = 4'b1111;
    out_ack = 1'b1;
    push_record(0);
    push_record(1);
    push_record(2);
    push_record(3);
    push_record(0);
    drain(80, cyc);
    req_rdy = 4'b0000;
    check_acks(0, 12, "rr_p0");
    check_acks(3, 4, "rr_p3");
  endtask

  task automatic test_stall();
    int cyc;
    apply_reset();
    req_rdy = 4'b0010;
    out_ack = 1'b1;
    push_record(1);
    wait_left(4, "stall");
    req_rdy = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (out_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_out_rdy: got %b, expected 0", out_rdy);
      end
      if (req_ack !== 4'b0000) begin
        errors++;
        $display("FAIL stall_req_ack: got %b, expected 0000", req_ack);
      end
    end
    @(posedge clk);
    #1;
    req_rdy = 4'b0010;
    @(negedge clk);
    checks++;
    if (out_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: got %b, expected 1", out_rdy);
    end
    drain(20, cyc);
    req_rdy = 4'b0000;
    check_acks(1, 6, "stall");
  endtask

  task automatic test_header_hold();
    int c;
    int cyc;
    apply_reset();
    req_rdy = 4'b0100;
    out_ack = 1'b0;
    c = 0;
    while (!out_rdy && c < 10) begin
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (out_rdy !== 1'b1 || out_data !== 8'hA2) begin
        errors++;
        $display("FAIL hold_header: got %b/%h, expected 1/a2",
                 out_rdy, out_data);
      end
      if (req_ack !== 4'b0000) begin
        errors++;
        $display("FAIL hold_req_ack: got %b, expected 0000", req_ack);
      end
      @(negedge clk);
    end
    check_acks(2, 0, "hold");
    push_record(2);
    @(posedge clk);
    #1;
    out_ack = 1'b1;
    drain(20, cyc);
    req_rdy = 4'b0000;
    check_acks(2, 6, "hold_done");
  endtask

  task automatic test_port_mask();
    int cyc;
    apply_reset();
    port_en = 4'b1010;
    req_rdy = 4'b1111;
    out_ack = 1'b1;
    push_record(1);
    push_record(3);
    push_record(1);
    push_record(3);
    drain(60, cyc);
    req_rdy = 4'b0000;
    check_acks(0, 0, "mask_p0");
    check_acks(2, 0, "mask_p2");
  endtask

  task automatic test_enable_drop();
    int cyc;
    apply_reset();
    port_en = 4'b0001;
    req_rdy = 4'b0001;
    out_ack = 1'b1;
    push_record(0);
    wait_left(6, "endrop");
    port_en = 4'b0000;
    drain(20, cyc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_rdy !== 1'b0) begin
        errors++;
        $display("FAIL endrop_idle: got %b, expected 0", out_rdy);
      end
    end
    req_rdy = 4'b0000;
    check_acks(0, 6, "endrop");
  endtask

  task automatic test_reset_mid();
    int cyc;
    apply_reset();
    req_rdy = 4'b0001;
    out_ack = 1'b1;
    push_record(0);
    wait_left(3, "rstmid");
    reset = 1'b1;
    #1;
    checks += 3;
    if (out_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_out_rdy: got %b, expected 0", out_rdy);
    end
    if (req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_req_ack: got %b, expected 0000", req_ack);
    end
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_out_data: got %h, expected 00", out_data);
    end
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_record(0);
    drain(20, cyc);
    req_rdy = 4'b0000;
    check_acks(0, 6, "rstmid");
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_header_hold();
    test_port_mask();
    test_enable_drop();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
